// File: rtl/gcd_checker.sv
// gcd_checker
//   Sequential response checker for the combinational gcd unit. Accepts an
//   (a, b, g) triple over a valid/ready handshake, recomputes the reference
//   GCD by subtractive Euclid (one subtraction per clock) and reports
//   pass/fail together with the reference value.
//
//   Optional feature macro: GCD_CHECKER_STATS_EN
//     defined   -> saturating pass/fail statistics counters are built
//     undefined -> pass_cnt / fail_cnt are tied to zero
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   in_valid  triple on a/b/g is valid
//   in_ready  checker idle, can accept a triple (decoded from state)
//   a, b      operands given to gcd
//   g         GCD reported by gcd
//   done      one-cycle pulse, result valid
//   pass      g matched the reference (held until next done)
//   expected  reference GCD (held until next done)
//   err       00 pass, 01 g > expected, 10 g < expected (held)
//   pass_cnt  saturating count of passes
//   fail_cnt  saturating count of fails
//
// state  | meaning
// IDLE   | waiting for a triple, in_ready high
// REDUCE | one Euclid subtraction per cycle until x==y or an operand is 0

module gcd_checker #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] g,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] expected,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic {IDLE, REDUCE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] gl;

  logic             terminal;
  logic [WIDTH-1:0] ref_val;
  logic             match;
  logic [1:0]       err_next;
  logic             finish;

  assign in_ready = (state == IDLE);

  // gcd(0,y)=y and gcd(x,0)=x; x==y also ends the reduction with ref=x.
  assign terminal = (x == y) || (x == '0) || (y == '0);
  assign ref_val  = (x == '0) ? y : x;
  assign match    = (gl == ref_val);
  assign err_next = match ? 2'b00 : ((gl > ref_val) ? 2'b01 : 2'b10);
  assign finish   = (state == REDUCE) && terminal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      gl       <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      expected <= '0;
      err      <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= a;
            y     <= b;
            gl    <= g;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (terminal) begin
            expected <= ref_val;
            pass     <= match;
            err      <= err_next;
            done     <= 1'b1;
            state    <= IDLE;
          end else if (x > y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_CHECKER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (finish) begin
      if (match) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_finish;
  assign unused_finish = finish;
  assign pass_cnt      = '0;
  assign fail_cnt      = '0;
`endif

endmodule

// File: tb/tb_gcd_checker.sv
module tb_gcd_checker;

  localparam int WIDTH   = 7;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef GCD_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] g = '0;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] expected;
  logic [1:0]       err;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  gcd_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .g(g), .done(done), .pass(pass), .expected(expected),
    .err(err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp_v;
    bit pass_v;
    int err_v;
    int acc;
    int lat;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  pass_m   = 0;
  int  fail_m   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: subtractive Euclid, returns result and subtraction count.
  function automatic void gcd_model(input int x0, input int y0, output int r, output int k);
    int x = x0;
    int y = y0;
    k = 0;
    while (!(x == y || x == 0 || y == 0)) begin
      if (x > y) x = x - y; else y = y - x;
      k++;
    end
    r = (x == 0) ? y : x;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int av, input int bv, input int gv);
    int   n = 0;
    int   r, k;
    sb_t  e;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    check_val("ready_before_send", int'(in_ready), 1);
    gcd_model(av, bv, r, k);
    e.exp_v  = r;
    e.pass_v = (gv == r);
    e.err_v  = (gv == r) ? 0 : ((gv > r) ? 1 : 2);
    e.acc    = cyc + 1;
    e.lat    = k + 1;
    sb.push_back(e);
    in_valid = 1'b1;
    a = WIDTH'(av);
    b = WIDTH'(bv);
    g = WIDTH'(gv);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    check_val("idle_timeout", int'(in_ready), 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (e.pass_v) pass_m = (pass_m == CNT_MAX) ? CNT_MAX : pass_m + 1;
        else          fail_m = (fail_m == CNT_MAX) ? CNT_MAX : fail_m + 1;
        check_val("latency", cyc - e.acc, e.lat);
        check_val("expected", int'(expected), e.exp_v);
        check_val("pass", int'(pass), int'(e.pass_v));
        check_val("err", int'(err), e.err_v);
        check_val("ready_at_done", int'(in_ready), 1);
        check_val("pass_cnt", int'(pass_cnt), STATS ? pass_m : 0);
        check_val("fail_cnt", int'(fail_cnt), STATS ? fail_m : 0);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, int'(in_ready), 1);
    check_val({tag, "_done"}, int'(done), 0);
    check_val({tag, "_pass"}, int'(pass), 0);
    check_val({tag, "_expected"}, int'(expected), 0);
    check_val({tag, "_err"}, int'(err), 0);
    check_val({tag, "_pass_cnt"}, int'(pass_cnt), 0);
    check_val({tag, "_fail_cnt"}, int'(fail_cnt), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_seen;
    #2;
    check_reset_vals("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a reduction aborts the check.
    send(90, 86, 2);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check_val("no_done_after_abort", done_seen, 0);
    check_val("ready_after_rst", int'(in_ready), 1);

    // Main function and boundaries.
    send(48, 12, 12);
    wait_idle();
    send(90, 86, 4);
    wait_idle();
    send(65, 4, 0);
    wait_idle();
    send(0, 0, 0);
    wait_idle();
    send(0, 54, 54);
    wait_idle();
    send(54, 0, 54);
    wait_idle();
    send(127, 1, 1);
    wait_idle();
    send(77, 77, 76);
    wait_idle();

    // Busy-time traffic is ignored; next triple accepted in the done cycle.
    send(100, 35, 5);
    begin
      int n = 0;
      while (!in_ready && n < 300) begin
        in_valid = 1'b1;
        a = WIDTH'($urandom_range(0, 127));
        b = WIDTH'($urandom_range(0, 127));
        g = WIDTH'($urandom_range(0, 127));
        @(negedge clk);
        n++;
      end
    end
    check_val("done_in_accept_cycle", int'(done), 1);
    send(12, 8, 4);
    wait_idle();

    // A few random triples, about half of them with the correct answer.
    for (int i = 0; i < 20; i++) begin
      int av, bv, r, k;
      av = $urandom_range(0, 127);
      bv = $urandom_range(0, 127);
      gcd_model(av, bv, r, k);
      send(av, bv, ($urandom_range(0, 1) == 1) ? r : $urandom_range(0, 127));
      wait_idle();
    end

    // Drive enough passes to saturate the pass counter.
    for (int i = 0; i < 260; i++) begin
      int v;
      v = (i % 127) + 1;
      send(v, v, v);
    end
    wait_idle();
    @(negedge clk);
    check_val("pass_cnt_sat", int'(pass_cnt), STATS ? CNT_MAX : 0);
    check_val("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_checker.md
# gcd_checker

Sequential response checker for the combinational `gcd` unit. It accepts an (A, B, GCD) triple through a valid/ready handshake and recomputes the reference GCD by subtractive Euclid, one subtraction per cycle. It then reports pass/fail with the expected value. It sits on the consuming side of the `gcd` outputs in the self-checking datapath, and also serves as a synthesizable on-chip monitor.

## Interface
Parameters:
- `WIDTH`, 7, operand and result width (matches `gcd` A/B/GCD)
- `CNT_W`, 8, width of the statistics counters

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  triple on `a`/`b`/`g` is valid
- `in_ready`  out  1  checker idle, can accept a triple
- `a`  in  WIDTH  operand A given to `gcd`
- `b`  in  WIDTH  operand B given to `gcd`
- `g`  in  WIDTH  GCD reported by `gcd`
- `done`  out  1  one-cycle pulse, result valid
- `pass`  out  1  `g` equals the reference; held until next `done`
- `expected`  out  WIDTH  reference GCD; held until next `done`
- `err`  out  2  00 pass, 01 `g` > expected, 10 `g` < expected; held until next `done`
- `pass_cnt`  out  CNT_W  saturating count of passes
- `fail_cnt`  out  CNT_W  saturating count of fails

## Operation
- States: IDLE, REDUCE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready` at a clock edge, latch x←`a`, y←`b`, gl←`g`, and enter REDUCE.
- REDUCE, each cycle:
  - Terminal when x==y, x==0 or y==0.
  - If terminal: ref = (x==0) ? y : x. At the next edge: `expected`←ref, `pass`←(gl==ref), `err` per the compare, `done`←1, state←IDLE.
  - Else if x>y: x←x−y.
  - Else: y←y−x.
- Definitions: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0.
- Arithmetic is unsigned WIDTH-bit. Subtraction only ever takes the smaller operand from the larger, so it never underflows.
- `done` is high for exactly one cycle, the same cycle `in_ready` returns high.
- A new triple may be accepted in the `done` cycle.
- `in_valid` while busy is ignored (not queued). Inputs are sampled only at acceptance.
- Counters, updated on the `done` edge:
  - `pass_cnt` increments on pass; `fail_cnt` on fail.
  - Both saturate at 2^CNT_W−1 with no wrap.

## Timing
- Reset (async, immediate) values: state IDLE, `in_ready`=1, `done`=0, `pass`=0, `expected`=0, `err`=00, `pass_cnt`=0, `fail_cnt`=0, x=y=gl=0.
- Reset mid-REDUCE aborts the check: no `done`, no counter update.
- Latency: with k subtractions, `done` is high k+1 edges after the accepting edge.
  - Minimum: 1 edge (a==b, or either operand 0).
  - WIDTH=7 worst case: (127,1), k=126, 127 edges.
- Throughput: one triple per k+1 cycles. Back-to-back acceptance is possible in the `done` cycle.
- All outputs are registered except `in_ready`, which is decoded from state.

## Configuration
- Macro: `GCD_CHECKER_STATS_EN`.
- Defined: `pass_cnt`/`fail_cnt` registers and saturating update logic are present.
- Undefined: no counter registers; `pass_cnt` and `fail_cnt` ports remain and are tied to 0. All other behaviour is identical.

## Test plan
- Reset mid-check: accept (90,86,g=2), assert `rst` 5 cycles later → outputs at reset values immediately; no `done`; counters 0; `in_ready`=1 after release.
- (48,12,g=12) → `done` 4 edges after acceptance; `expected`=12, `pass`=1, `err`=00, `pass_cnt`=1.
- (90,86,g=4) → `done` 24 edges after acceptance; `expected`=2, `pass`=0, `err`=01, `fail_cnt`=1. Then (65,4,g=0) → `expected`=1, `err`=10.
- Boundaries:
  - (0,0,g=0) → `done` after 1 edge, `expected`=0, pass.
  - (0,54,g=54) → `expected`=54, pass.
  - (127,1,g=1) → `done` after 127 edges, pass.
- Handshake: `in_valid` held high with changing inputs during REDUCE → inputs ignored. New triple (12,8,g=4) accepted in the `done` cycle → `done` 3 edges later, pass.
- Stats (macro defined): 260 passing triples → `pass_cnt` saturates at 255. Macro undefined → both counters read 0 throughout.
